song_menu_fsm: RTL and testbench

Parametrised song-select and high-score controller for the game front end. It generalises the three-song menu to NUM_SONGS entries and offers optional menu wrap-around. Buttons act on rising edges only, and an abort path leaves a game without scoring. It holds a per-song high-score table in binary and ASCII form, drives the video layer's menu highlight and score text, and starts or stops the scoring/compare pipeline.

---
 rtl/song_menu_fsm_if.sv | 34 +++
 rtl/song_menu_fsm.sv | 130 +++++++++++++
 tb/tb_song_menu_fsm.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_menu_fsm_if.sv
// Front-end bus between the button/scoring side and the song menu controller.
// The master drives buttons and final scores; the slave returns menu and score display state.
interface song_menu_fsm_if #(
   parameter int NUM_SONGS = 4,
   parameter int SCORE_W   = 18,
   parameter int CHARS     = 6
);
   localparam int SEL_W = $clog2(NUM_SONGS);

   logic                 up;
   logic                 down;
   logic                 enter;
   logic                 abort;
   logic                 done;
   logic [SCORE_W-1:0]   score_bin;
   logic [8*CHARS-1:0]   score_ascii;

   logic [SEL_W-1:0]     menu_sel;
   logic                 in_game;
   logic                 reset_comp;
   logic [SEL_W-1:0]     song;
   logic [8*CHARS-1:0]   high_score;
   logic                 new_record;

   modport master (
      output up, down, enter, abort, done, score_bin, score_ascii,
      input  menu_sel, in_game, reset_comp, song, high_score, new_record
   );

   modport slave (
      input  up, down, enter, abort, done, score_bin, score_ascii,
      output menu_sel, in_game, reset_comp, song, high_score, new_record
   );
endinterface

// File: rtl/song_menu_fsm.sv
// Song-select menu and per-song high-score table: edge-detected buttons drive the
// highlight, a game runs START->PLAY, and COMMIT records strictly better scores.
module song_menu_fsm #(
   parameter int NUM_SONGS = 4,
   parameter int SCORE_W   = 18,
   parameter int CHARS     = 6,
   parameter bit WRAP      = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   song_menu_fsm_if.slave    bus
);
   localparam int SEL_W = $clog2(NUM_SONGS);
   localparam int TXT_W = 8 * CHARS;
   localparam logic [SEL_W-1:0] LAST      = SEL_W'(NUM_SONGS - 1);
   localparam logic [TXT_W-1:0] ZERO_TEXT = {CHARS{8'h30}};

   typedef enum logic [1:0] {MENU, START, PLAY, COMMIT} state_t;

   state_t               state;
   logic [SEL_W-1:0]     menu_sel;
   logic [SEL_W-1:0]     song;
   logic                 in_game;
   logic                 reset_comp;
   logic                 new_record;
   logic [TXT_W-1:0]     high_score;
   logic                 u_q, d_q, e_q;
   logic [SCORE_W-1:0]   score_bin_q;
   logic [TXT_W-1:0]     score_ascii_q;
   logic [SCORE_W-1:0]   table_bin   [NUM_SONGS];
   logic [TXT_W-1:0]     table_ascii [NUM_SONGS];

   logic                 up_edge, down_edge, enter_edge;
   logic [SEL_W-1:0]     sel_prev, sel_next;

   assign up_edge    = bus.up    & ~u_q;
   assign down_edge  = bus.down  & ~d_q;
   assign enter_edge = bus.enter & ~e_q;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      sel_prev = menu_sel - SEL_W'(1);
      sel_next = menu_sel + SEL_W'(1);
      if (menu_sel == '0)
         sel_prev = WRAP ? LAST : '0;
      if (menu_sel == LAST)
         sel_next = WRAP ? '0 : LAST;
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= MENU;
         menu_sel      <= '0;
         song          <= '0;
         in_game       <= 1'b0;
         reset_comp    <= 1'b0;
         new_record    <= 1'b0;
         high_score    <= ZERO_TEXT;
         u_q           <= 1'b0;
         d_q           <= 1'b0;
         e_q           <= 1'b0;
         score_bin_q   <= '0;
         score_ascii_q <= ZERO_TEXT;
         // NOTE: the score table is a small register array and must be reset, unlike a RAM.
         for (int i = 0; i < NUM_SONGS; i++) begin
            table_bin[i]   <= '0;
            table_ascii[i] <= ZERO_TEXT;
         end
      end else begin
         u_q        <= bus.up;
         d_q        <= bus.down;
         e_q        <= bus.enter;
         reset_comp <= 1'b0;
         new_record <= 1'b0;

         unique case (state)
            MENU: begin
               high_score <= table_ascii[menu_sel];
               if (enter_edge) begin
                  state      <= START;
                  song       <= menu_sel;
                  in_game    <= 1'b1;
                  reset_comp <= 1'b1;
               end else if (up_edge && !down_edge) begin
                  menu_sel <= sel_prev;
               end else if (down_edge && !up_edge) begin
                  menu_sel <= sel_next;
               end
            end

            START: begin
               state <= PLAY;
            end

            PLAY: begin
               // done outranks abort so a finishing game is always scored
               if (bus.done) begin
                  score_bin_q   <= bus.score_bin;
                  score_ascii_q <= bus.score_ascii;
                  state         <= COMMIT;
                  in_game       <= 1'b0;
               end else if (bus.abort) begin
                  state   <= MENU;
                  in_game <= 1'b0;
               end
            end

            COMMIT: begin
               if (score_bin_q > table_bin[song]) begin
                  table_bin[song]   <= score_bin_q;
                  table_ascii[song] <= score_ascii_q;
                  new_record        <= 1'b1;
               end
               menu_sel <= song;
               state    <= MENU;
            end

            default: state <= MENU;
         endcase
      end
   end

   assign bus.menu_sel   = menu_sel;
   assign bus.in_game    = in_game;
   assign bus.reset_comp = reset_comp;
   assign bus.song       = song;
   assign bus.high_score = high_score;
   assign bus.new_record = new_record;
endmodule

// File: tb/tb_song_menu_fsm.sv
// Bench for song_menu_fsm: one wrapping and one saturating instance share stimulus and
// are checked every cycle against a behavioural model, plus a navigation table and game sequences.
module tb_song_menu_fsm;
   localparam int NS = 4;
   localparam int SW = 18;
   localparam int CH = 6;
   localparam logic [47:0] ZERO_TEXT = {CH{8'h30}};
   localparam int PH_MENU = 0, PH_START = 1, PH_PLAY = 2, PH_COMMIT = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          up, down, enter, abort, done;
   logic [SW-1:0] score_bin;
   logic [47:0]   score_ascii;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   song_menu_fsm_if #(.NUM_SONGS(NS), .SCORE_W(SW), .CHARS(CH)) if_w ();
   song_menu_fsm_if #(.NUM_SONGS(NS), .SCORE_W(SW), .CHARS(CH)) if_s ();

   assign if_w.up = up;       assign if_s.up = up;
   assign if_w.down = down;   assign if_s.down = down;
   assign if_w.enter = enter; assign if_s.enter = enter;
   assign if_w.abort = abort; assign if_s.abort = abort;
   assign if_w.done = done;   assign if_s.done = done;
   assign if_w.score_bin = score_bin;     assign if_s.score_bin = score_bin;
   assign if_w.score_ascii = score_ascii; assign if_s.score_ascii = score_ascii;

   song_menu_fsm #(.NUM_SONGS(NS), .SCORE_W(SW), .CHARS(CH), .WRAP(1'b1)) dut_w (
      .clk(clk), .reset(reset), .bus(if_w.slave));
   song_menu_fsm #(.NUM_SONGS(NS), .SCORE_W(SW), .CHARS(CH), .WRAP(1'b0)) dut_s (
      .clk(clk), .reset(reset), .bus(if_s.slave));

   // Behavioural model, index 0 = wrapping instance, 1 = saturating instance
   int          m_phase [2];
   int          m_sel   [2];
   int          m_song  [2];
   bit          m_ing [2], m_rc [2], m_nr [2];
   bit          m_up_old [2], m_dn_old [2], m_en_old [2];
   int unsigned m_best  [2][NS];
   logic [47:0] m_text  [2][NS];
   logic [47:0] m_hs    [2];
   int unsigned m_pend_b [2];
   logic [47:0] m_pend_a [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] to_text(input int unsigned v);
      logic [47:0] t;
      int unsigned x;
      x = v;
      for (int i = 0; i < CH; i++) begin
         t[8*i +: 8] = 8'h30 + 8'(x % 10);
         x = x / 10;
      end
      return t;
   endfunction

   task automatic model_reset(input int k);
      m_phase[k] = PH_MENU; m_sel[k] = 0; m_song[k] = 0;
      m_ing[k] = 0; m_rc[k] = 0; m_nr[k] = 0; m_hs[k] = ZERO_TEXT;
      m_up_old[k] = 0; m_dn_old[k] = 0; m_en_old[k] = 0;
      for (int i = 0; i < NS; i++) begin
         m_best[k][i] = 0;
         m_text[k][i] = ZERO_TEXT;
      end
   endtask

   task automatic model_step(input int k, input bit wraps);
      bit press_up, press_dn, press_en;
      press_up = up && !m_up_old[k];
      press_dn = down && !m_dn_old[k];
      press_en = enter && !m_en_old[k];
      m_up_old[k] = up; m_dn_old[k] = down; m_en_old[k] = enter;
      m_rc[k] = 0; m_nr[k] = 0;
      if (m_phase[k] == PH_MENU) begin
         m_hs[k] = m_text[k][m_sel[k]];
         if (press_en) begin
            m_phase[k] = PH_START; m_song[k] = m_sel[k]; m_ing[k] = 1; m_rc[k] = 1;
         end else if (press_up && !press_dn) begin
            if (wraps) m_sel[k] = (m_sel[k] + NS - 1) % NS;
            else if (m_sel[k] > 0) m_sel[k] = m_sel[k] - 1;
         end else if (press_dn && !press_up) begin
            if (wraps) m_sel[k] = (m_sel[k] + 1) % NS;
            else if (m_sel[k] < NS - 1) m_sel[k] = m_sel[k] + 1;
         end
      end else if (m_phase[k] == PH_START) begin
         m_phase[k] = PH_PLAY;
      end else if (m_phase[k] == PH_PLAY) begin
         if (done) begin
            m_pend_b[k] = score_bin; m_pend_a[k] = score_ascii;
            m_phase[k] = PH_COMMIT; m_ing[k] = 0;
         end else if (abort) begin
            m_phase[k] = PH_MENU; m_ing[k] = 0;
         end
      end else begin
         if (m_pend_b[k] > m_best[k][m_song[k]]) begin
            m_best[k][m_song[k]] = m_pend_b[k];
            m_text[k][m_song[k]] = m_pend_a[k];
            m_nr[k] = 1;
         end
         m_sel[k] = m_song[k];
         m_phase[k] = PH_MENU;
      end
   endtask

   task automatic model_compare(input int k, input logic [1:0] sel, input logic ig, input logic rc,
                                input logic [1:0] sg, input logic [47:0] hs, input logic nr);
      check($sformatf("m%0d_menu_sel", k), 64'(sel), 64'(m_sel[k]));
      check($sformatf("m%0d_in_game", k), 64'(ig), 64'(m_ing[k]));
      check($sformatf("m%0d_reset_comp", k), 64'(rc), 64'(m_rc[k]));
      check($sformatf("m%0d_song", k), 64'(sg), 64'(m_song[k]));
      check($sformatf("m%0d_high_score", k), 64'(hs), 64'(m_hs[k]));
      check($sformatf("m%0d_new_record", k), 64'(nr), 64'(m_nr[k]));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) begin
         model_reset(0); model_reset(1);
      end else begin
         model_step(0, 1'b1); model_step(1, 1'b0);
      end
      #1;
      model_compare(0, if_w.menu_sel, if_w.in_game, if_w.reset_comp, if_w.song, if_w.high_score, if_w.new_record);
      model_compare(1, if_s.menu_sel, if_s.in_game, if_s.reset_comp, if_s.song, if_s.high_score, if_s.new_record);
   endtask

   task automatic do_reset();
      reset = 1'b1; cycle(); cycle(); reset = 1'b0;
   endtask

   // Enter on the current entry, play, then finish with done and/or abort.
   task automatic play_song(input int unsigned sc, input bit use_done, input bit use_abort,
                            output logic nr, output logic [47:0] hs);
      enter = 1'b1; cycle(); enter = 1'b0;
      check("start_reset_comp", 64'(if_w.reset_comp), 64'd1);
      check("start_in_game", 64'(if_w.in_game), 64'd1);
      cycle();
      check("play_reset_comp", 64'(if_w.reset_comp), 64'd0);
      check("play_in_game", 64'(if_w.in_game), 64'd1);
      cycle();
      score_bin = SW'(sc); score_ascii = to_text(sc);
      done = use_done; abort = use_abort;
      cycle();
      done = 1'b0; abort = 1'b0;
      cycle();
      nr = if_w.new_record;
      cycle();
      hs = if_w.high_score;
   endtask

   typedef struct packed {
      logic       up;
      logic       down;
      logic [1:0] exp_wrap;
      logic [1:0] exp_sat;
   } nav_vec_t;

   nav_vec_t    nav [$];
   logic        nr;
   logic [47:0] hs;

   initial begin
      reset = 1'b1; up = 0; down = 0; enter = 0; abort = 0; done = 0;
      score_bin = '0; score_ascii = ZERO_TEXT;

      // {up, down, menu_sel wrap, menu_sel saturate} after each cycle
      nav = '{
         '{1'b0,1'b1,2'd1,2'd1}, '{1'b0,1'b0,2'd1,2'd1},
         '{1'b0,1'b1,2'd2,2'd2}, '{1'b0,1'b0,2'd2,2'd2},
         '{1'b0,1'b1,2'd3,2'd3}, '{1'b0,1'b0,2'd3,2'd3},
         '{1'b0,1'b1,2'd0,2'd3}, '{1'b0,1'b0,2'd0,2'd3},
         '{1'b1,1'b0,2'd3,2'd2}, '{1'b0,1'b0,2'd3,2'd2},
         '{1'b1,1'b1,2'd3,2'd2}, '{1'b0,1'b0,2'd3,2'd2},
         '{1'b1,1'b0,2'd2,2'd1}, '{1'b0,1'b0,2'd2,2'd1},
         '{1'b1,1'b0,2'd1,2'd0}, '{1'b0,1'b0,2'd1,2'd0},
         '{1'b1,1'b0,2'd0,2'd0}, '{1'b0,1'b0,2'd0,2'd0},
         '{1'b1,1'b0,2'd3,2'd0}, '{1'b0,1'b0,2'd3,2'd0}
      };
      for (int i = 0; i < 10; i++) nav.push_back('{1'b0,1'b1,2'd0,2'd1});
      nav.push_back('{1'b0,1'b0,2'd0,2'd1});

      do_reset();
      check("reset_menu_sel", 64'(if_w.menu_sel), 64'd0);
      check("reset_in_game", 64'(if_w.in_game), 64'd0);
      check("reset_high_score", 64'(if_w.high_score), 64'(ZERO_TEXT));

      foreach (nav[i]) begin
         up = nav[i].up; down = nav[i].down;
         cycle();
         check($sformatf("nav%0d_wrap", i), 64'(if_w.menu_sel), 64'(nav[i].exp_wrap));
         check($sformatf("nav%0d_sat", i), 64'(if_s.menu_sel), 64'(nav[i].exp_sat));
      end
      up = 0; down = 0;

      // Select song 2 and record a first score
      do_reset();
      down = 1; cycle(); down = 0; cycle();
      down = 1; cycle(); down = 0; cycle();
      check("sel_song2", 64'(if_w.menu_sel), 64'd2);
      play_song(1234, 1'b1, 1'b0, nr, hs);
      check("first_record", 64'(nr), 64'd1);
      check("first_hs", 64'(hs), 64'(to_text(1234)));
      check("return_sel", 64'(if_w.menu_sel), 64'd2);
      check("song_idx", 64'(if_w.song), 64'd2);

      play_song(1234, 1'b1, 1'b0, nr, hs);
      check("equal_no_write", 64'(nr), 64'd0);
      check("equal_hs", 64'(hs), 64'(to_text(1234)));
      play_song(1233, 1'b1, 1'b0, nr, hs);
      check("lower_no_write", 64'(nr), 64'd0);
      play_song(5000, 1'b1, 1'b0, nr, hs);
      check("higher_write", 64'(nr), 64'd1);
      check("higher_hs", 64'(hs), 64'(to_text(5000)));
      play_song(9999, 1'b0, 1'b1, nr, hs);
      check("abort_no_write", 64'(nr), 64'd0);
      check("abort_hs", 64'(hs), 64'(to_text(5000)));
      play_song(9999, 1'b1, 1'b1, nr, hs);
      check("done_beats_abort", 64'(nr), 64'd1);
      check("done_abort_hs", 64'(hs), 64'(to_text(9999)));

      // Reset in the middle of a game clears the whole table
      enter = 1; cycle(); enter = 0; cycle();
      check("pre_reset_in_game", 64'(if_w.in_game), 64'd1);
      reset = 1; cycle();
      check("midgame_in_game", 64'(if_w.in_game), 64'd0);
      check("midgame_sel", 64'(if_w.menu_sel), 64'd0);
      reset = 0; cycle();
      check("cleared_hs0", 64'(if_w.high_score), 64'(ZERO_TEXT));
      for (int i = 1; i < NS; i++) begin
         down = 1; cycle(); down = 0; cycle();
         check($sformatf("cleared_hs%0d", i), 64'(if_w.high_score), 64'(ZERO_TEXT));
      end

      // Randomised traffic against the model
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 399) == 0);
         up    = ($urandom_range(0, 2) == 0);
         down  = ($urandom_range(0, 2) == 0);
         enter = ($urandom_range(0, 5) == 0);
         done  = ($urandom_range(0, 5) == 0);
         abort = ($urandom_range(0, 7) == 0);
         score_bin   = SW'($urandom_range(0, 3000));
         score_ascii = to_text(32'(score_bin));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
